line_mem_ctrl: RTL and testbench
================================

Name: line_mem_ctrl

Overview:
Parametrised successor to the single-port line memory. It provides DEPTH lines of INW bits behind a valid/ready request channel and a valid/ready response channel. Writes can be masked per DATAW-bit word, and read latency is configurable. A credit-controlled response FIFO absorbs backpressure, so the block can sit between the fetch/load units and the line store without stalling the pipeline.

Parameters:
DATAW, 16, word width in bits; write-mask granularity
INW, 512, line width in bits
ADDRW, 32, byte address width
DEPTH, 64, number of lines (power of 2, >=2)
RD_LAT, 2, request-accept to response-FIFO-entry latency in cycles (>=1)
RESP_DEPTH, 4, response FIFO entries (>=RD_LAT+1)
NUMWORDS, INW/DATAW, derived: words per line

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is synchronous and active-high
req_valid  in  1  request present
req_ready  out  1  request may be accepted this cycle
req_write  in  1  1=write, 0=read
req_addr  in  ADDRW  byte address of line
req_wmask  in  NUMWORDS  per-word write enable (writes only)
req_data  in  INW  write data
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts response
resp_write  out  1  response belongs to a write
resp_err  out  1  address out of range
resp_data  out  INW  read data; 0 for writes and errors

Behaviour:
- Line index = req_addr[log2(INW/8)+log2(DEPTH)-1 : log2(INW/8)]. Offset bits are ignored. Any set bit above the index field is out of range.
- Accept occurs when req_valid && req_ready at a rising edge.
- Every accepted request, read or write, produces exactly one response. Responses return in acceptance order.
- Credits: inflight = requests in the latency pipe + FIFO occupancy. req_ready = !rst && (inflight < RESP_DEPTH). The credit check uses registered state only; a same-cycle resp pop does not free a credit until the next cycle.
- Write to an in-range address: the array is updated at the accept edge for words whose req_wmask bit is 1. Other words are unchanged. req_wmask = 0 is legal and gives a no-op write with a normal ack.
- Read: returns array contents as of the accept edge. A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Out-of-range request: no array access, resp_err=1, resp_data=0. The request still consumes a credit and keeps its order.
- Latency: a request accepted at edge N enters the FIFO at edge N+RD_LAT. If the FIFO is empty, resp_valid is high in the cycle after edge N+RD_LAT.
- FIFO head is output-registered. Pop occurs on resp_valid && resp_ready. Push and pop in the same cycle are legal, including when the FIFO is full.
- resp_* outputs must stay stable while resp_valid && !resp_ready.
- Read and write pointers wrap modulo RESP_DEPTH. Full and empty are distinguished by an occupancy counter of width log2(RESP_DEPTH)+1.
- Reset, including reset mid-operation: the latency pipe and FIFO are flushed, and in-flight responses are dropped. Outputs after reset: req_ready=0 while rst is high, then 1; resp_valid=0, resp_write=0, resp_err=0, resp_data=0.
- Array contents are not reset. The bench must not read a line before it has been written.

Optional Feature:
LINE_MEM_PARITY_EN:
- Defined: one even-parity bit is stored per word and written with that word. On a read, each word's parity is recomputed. Extra output port resp_perr (NUMWORDS bits, reset 0) flags mismatching words with the same timing as resp_data. Extra input inj_perr (1 bit): when it is high at a write accept, the stored parity of each written word is inverted.
- Undefined: no parity storage, and neither port exists.

Decomposition:
- Package line_mem_pkg holds:
  - typedef line_t [INW-1:0], word_mask_t [NUMWORDS-1:0], line_idx_t
  - constant OFFS_BITS = log2(INW/8)
  - struct resp_t {write, err, data}
- One sub-module, line_mem_resp_fifo: a parametrised depth/width FIFO with occupancy output. It is instantiated with resp_t entries.

Test Plan:
- Write 0x..AA line to idx 3 with full mask, then read idx 3 -> resp_data = written line, resp_write=0, resp_err=0, response in the cycle after edge accept+RD_LAT.
- Write idx 5 with mask 0x0001 and data word0=0x1234 over a prior line of 0xFFFF words -> readback word0=0x1234, words1..31=0xFFFF.
- Addr = DEPTH*(INW/8) (first out-of-range) -> resp_err=1, resp_data=0, later read of idx 0 unchanged.
- Hold resp_ready=0 and issue back-to-back reads -> exactly RESP_DEPTH accepted, req_ready=0 afterwards. Release resp_ready -> responses arrive in order with no loss or duplication; req_ready returns 1 one cycle after the first pop.
- Back-to-back write idx 7 then read idx 7 on consecutive edges -> read returns new data.
- Assert rst with 3 requests in flight -> resp_valid=0 the cycle after reset. After reset deasserts, no stale responses appear, and req_ready=1 from the first cycle after rst deasserts.

Source files
------------

// File: rtl/line_mem_pkg.sv
// line_mem_pkg: shared constants, types and parity helper for line_mem_ctrl
// LINE_MEM_PARITY_EN adds a per-word parity-error field to resp_t
package line_mem_pkg;
  localparam int LM_DATAW = 16;
  localparam int LM_INW = 512;
  localparam int LM_ADDRW = 32;
  localparam int LM_DEPTH = 64;
  localparam int LM_NUMWORDS = LM_INW / LM_DATAW;
  localparam int OFFS_BITS = $clog2(LM_INW / 8);
  localparam int IDX_BITS = $clog2(LM_DEPTH);
  typedef logic [LM_INW-1:0] line_t;
  typedef logic [LM_NUMWORDS-1:0] word_mask_t;
  typedef logic [IDX_BITS-1:0] line_idx_t;
  typedef struct packed {
    logic write;
    logic err;
    line_t data;
`ifdef LINE_MEM_PARITY_EN
    word_mask_t perr;
`endif
  } resp_t;
  function automatic word_mask_t word_par(line_t l);
    for (int w = 0; w < LM_NUMWORDS; w++) word_par[w] = ^l[w*LM_DATAW +: LM_DATAW];
  endfunction
endpackage

// File: rtl/line_mem_resp_fifo.sv
// line_mem_resp_fifo: FIFO of T entries with registered storage and occupancy count
module line_mem_resp_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  input logic push,
  input T din,
  input logic pop,
  output T dout,
  output logic valid,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  T mem [DEPTH];
  logic [PW-1:0] rptr, wptr;
  logic popv;
  assign valid = count != '0;
  assign popv = pop && valid;
  always_comb begin
    dout = '0;
    if (valid) dout = mem[rptr];
  end
  always_ff @(posedge clk)
    if (rst) begin
      rptr <= '0;
      wptr <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr == PW'(DEPTH - 1) ? '0 : wptr + PW'(1);
      if (popv) rptr <= rptr == PW'(DEPTH - 1) ? '0 : rptr + PW'(1);
      count <= count + CW'(push) - CW'(popv);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
endmodule

// File: rtl/line_mem_ctrl.sv
// line_mem_ctrl: masked-write line memory with fixed-latency responses and a credit-managed response FIFO
// LINE_MEM_PARITY_EN adds per-word even parity, resp_perr and inj_perr
module line_mem_ctrl
  import line_mem_pkg::*;
#(
  parameter int DATAW = LM_DATAW,
  parameter int INW = LM_INW,
  parameter int ADDRW = LM_ADDRW,
  parameter int DEPTH = LM_DEPTH,
  parameter int RD_LAT = 2,
  parameter int RESP_DEPTH = 4,
  localparam int NUMWORDS = INW / DATAW
) (
  input logic clk,
  input logic rst,
  input logic req_valid,
  output logic req_ready,
  input logic req_write,
  input logic [ADDRW-1:0] req_addr,
  input logic [NUMWORDS-1:0] req_wmask,
  input logic [INW-1:0] req_data,
  output logic resp_valid,
  input logic resp_ready,
  output logic resp_write,
  output logic resp_err,
  output logic [INW-1:0] resp_data
`ifdef LINE_MEM_PARITY_EN
  ,
  output logic [NUMWORDS-1:0] resp_perr,
  input logic inj_perr
`endif
);
  logic [INW-1:0] mem [DEPTH];
`ifdef LINE_MEM_PARITY_EN
  logic [NUMWORDS-1:0] par [DEPTH];
`endif
  line_idx_t idx;
  logic oor, acc, unused;
  resp_t ent, head;
  resp_t pipe [RD_LAT];
  logic [RD_LAT-1:0] pv;
  logic [$clog2(RESP_DEPTH):0] occ;
  int inflight;
  assign idx = req_addr[OFFS_BITS +: IDX_BITS];
  assign oor = |req_addr[ADDRW-1:OFFS_BITS+IDX_BITS];
  assign unused = ^req_addr[OFFS_BITS-1:0];
  assign acc = req_valid && req_ready;
  // credits count only registered state, so a pop frees its slot one cycle later
  always_comb begin
    inflight = int'(occ);
    for (int i = 0; i < RD_LAT; i++) inflight += int'(pv[i]);
  end
  assign req_ready = !rst && (inflight < RESP_DEPTH);
  always_comb begin
    ent = '0;
    ent.write = req_write;
    ent.err = oor;
    if (!req_write && !oor) ent.data = mem[idx];
`ifdef LINE_MEM_PARITY_EN
    if (!req_write && !oor) ent.perr = word_par(mem[idx]) ^ par[idx];
`endif
  end
  always_ff @(posedge clk)
    if (acc && req_write && !oor)
      for (int w = 0; w < NUMWORDS; w++)
        if (req_wmask[w]) begin
          mem[idx][w*DATAW +: DATAW] <= req_data[w*DATAW +: DATAW];
`ifdef LINE_MEM_PARITY_EN
          par[idx][w] <= ^req_data[w*DATAW +: DATAW] ^ inj_perr;
`endif
        end
  always_ff @(posedge clk)
    if (rst) pv <= '0;
    else begin
      pv[0] <= acc;
      for (int i = 1; i < RD_LAT; i++) pv[i] <= pv[i-1];
    end
  always_ff @(posedge clk) begin
    pipe[0] <= ent;
    for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
  end
  line_mem_resp_fifo #(.T(resp_t), .DEPTH(RESP_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(pv[RD_LAT-1]),
    .din(pipe[RD_LAT-1]),
    .pop(resp_ready),
    .dout(head),
    .valid(resp_valid),
    .count(occ)
  );
  assign resp_write = head.write;
  assign resp_err = head.err;
  assign resp_data = head.data;
`ifdef LINE_MEM_PARITY_EN
  assign resp_perr = head.perr;
`endif
endmodule

// File: tb/tb_line_mem_ctrl.sv
// tb_line_mem_ctrl: directed self-checking bench for line_mem_ctrl (RD_LAT=2, RESP_DEPTH=4)
module tb_line_mem_ctrl;
  localparam int NW = 32;
  logic clk = 0, rst = 1;
  logic req_valid = 0, req_write = 0, resp_ready = 1;
  logic [31:0] req_addr = 0;
  logic [NW-1:0] req_wmask = 0;
  logic [511:0] req_data = 0;
  logic req_ready, resp_valid, resp_write, resp_err;
  logic [511:0] resp_data;
`ifdef LINE_MEM_PARITY_EN
  logic [NW-1:0] resp_perr, last_perr;
  logic inj_perr = 0;
`endif
  int checks = 0, errors = 0, cyc = 0;
  logic [511:0] pat_aa, pat_m, pat_p, pat_q;

  line_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wmask(req_wmask), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_err(resp_err), .resp_data(resp_data)
`ifdef LINE_MEM_PARITY_EN
    , .resp_perr(resp_perr), .inj_perr(inj_perr)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic send(input logic w, input logic [31:0] a, input logic [NW-1:0] m,
                      input logic [511:0] d, output int at);
    logic rdy;
    at = -1;
    req_write = w; req_addr = a; req_wmask = m; req_data = d; req_valid = 1;
    for (int k = 0; k < 50 && at < 0; k++) begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) at = cyc;
    end
    req_valid = 0;
    if (at < 0) begin
      errors++;
      $display("FAIL send_timeout addr=%h not accepted within 50 cycles", a);
    end
  endtask

  task automatic get_resp(output logic w, output logic e, output logic [511:0] d, output int at);
    at = -1; w = 1'bx; e = 1'bx; d = 'x;
    for (int k = 0; k < 50 && at < 0; k++) begin
      if (resp_valid) begin
        w = resp_write; e = resp_err; d = resp_data; at = cyc;
`ifdef LINE_MEM_PARITY_EN
        last_perr = resp_perr;
`endif
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", req_ready); end
    checks++;
    if ({resp_valid, resp_write, resp_err, resp_data} !== '0) begin
      errors++; $display("FAIL rst_resp valid=%b write=%b err=%b data=%h want all 0", resp_valid, resp_write, resp_err, resp_data);
    end
    rst = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_write_read;
    int a, r; logic w, e; logic [511:0] d;
    send(1, 32'hC0, '1, pat_aa, a);
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b10 || d !== '0 || r !== a + 2) begin
      errors++; $display("FAIL wr_ack write=%b err=%b lat=%0d data=%h want write=1 err=0 lat=2 data=0", w, e, r - a, d);
    end
    send(0, 32'hC0, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b00 || d !== pat_aa || r !== a + 2) begin
      errors++; $display("FAIL rd_idx3 write=%b err=%b lat=%0d data=%h want 0 0 2 %h", w, e, r - a, d, pat_aa);
    end
    send(0, 32'hFF, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b00 || d !== pat_aa) begin
      errors++; $display("FAIL rd_offset err=%b data=%h want err=0 data=%h", e, d, pat_aa);
    end
  endtask

  task automatic test_mask;
    int a, r; logic w, e; logic [511:0] d;
    send(1, 32'h140, '1, {32{16'hFFFF}}, a);
    get_resp(w, e, d, r);
    send(1, 32'h140, 32'h1, {{31{16'hDEAD}}, 16'h1234}, a);
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b10 || d !== '0) begin
      errors++; $display("FAIL mask_ack write=%b err=%b data=%h want 1 0 0", w, e, d);
    end
    send(0, 32'h140, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (d !== pat_m) begin errors++; $display("FAIL mask_rd data=%h want %h", d, pat_m); end
    send(1, 32'h140, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b10) begin errors++; $display("FAIL nomask_ack write=%b err=%b want 1 0", w, e); end
    send(0, 32'h140, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (d !== pat_m) begin errors++; $display("FAIL nomask_rd data=%h want %h", d, pat_m); end
  endtask

  task automatic test_oor;
    int a, r; logic w, e; logic [511:0] d;
    send(1, 32'h0, '1, pat_p, a);
    get_resp(w, e, d, r);
    send(1, 32'hFC0, '1, pat_q, a);
    get_resp(w, e, d, r);
    send(1, 32'h1000, '1, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b11 || d !== '0 || r !== a + 2) begin
      errors++; $display("FAIL oor_wr write=%b err=%b lat=%0d data=%h want 1 1 2 0", w, e, r - a, d);
    end
    send(0, 32'h1000, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b01 || d !== '0) begin
      errors++; $display("FAIL oor_rd write=%b err=%b data=%h want 0 1 0", w, e, d);
    end
    send(0, 32'h8000_0000, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (e !== 1'b1 || d !== '0) begin errors++; $display("FAIL oor_msb err=%b data=%h want 1 0", e, d); end
    send(0, 32'hFC0, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (e !== 1'b0 || d !== pat_q) begin errors++; $display("FAIL last_idx err=%b data=%h want 0 %h", e, d, pat_q); end
    send(0, 32'h0, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (e !== 1'b0 || d !== pat_p) begin errors++; $display("FAIL idx0_intact err=%b data=%h want 0 %h", e, d, pat_p); end
  endtask

  task automatic test_backpressure;
    logic [31:0] addrs [4];
    logic [511:0] exp [4];
    int n; logic rdy;
    addrs[0] = 32'hC0; addrs[1] = 32'h140; addrs[2] = 32'h0; addrs[3] = 32'hFC0;
    exp[0] = pat_aa; exp[1] = pat_m; exp[2] = pat_p; exp[3] = pat_q;
    resp_ready = 0;
    n = 0;
    req_write = 0; req_wmask = '0; req_data = '0;
    for (int k = 0; k < 12; k++) begin
      req_addr = addrs[n < 4 ? n : 0];
      req_valid = 1;
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) n++;
    end
    req_valid = 0;
    checks++;
    if (n !== 4) begin errors++; $display("FAIL bp_accepts got=%0d want=4", n); end
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b want=0", req_ready); end
    checks++;
    if (resp_valid !== 1'b1 || resp_data !== pat_aa) begin
      errors++; $display("FAIL bp_head_hold valid=%b data=%h want 1 %h", resp_valid, resp_data, pat_aa);
    end
    resp_ready = 1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_same_cycle got=%b want=0", req_ready); end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (resp_valid !== 1'b1 || resp_write !== 1'b0 || resp_data !== exp[k]) begin
        errors++; $display("FAIL bp_order k=%0d valid=%b data=%h want 1 %h", k, resp_valid, resp_data, exp[k]);
      end
      @(posedge clk);
      #1;
      if (k == 0) begin
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_after_pop got=%b want=1", req_ready); end
      end
    end
    checks++;
    if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup valid=%b want=0", resp_valid); end
  endtask

  task automatic test_back_to_back;
    int a1, a2, r; logic w, e; logic [511:0] d, x;
    x = {16{32'h0BADF00D}};
    send(1, 32'h1C0, '1, x, a1);
    send(0, 32'h1C0, '0, '0, a2);
    checks++;
    if (a2 !== a1 + 1) begin errors++; $display("FAIL b2b_accept gap=%0d want=1", a2 - a1); end
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b10) begin errors++; $display("FAIL b2b_wr_ack write=%b err=%b want 1 0", w, e); end
    get_resp(w, e, d, r);
    checks++;
    if ({w, e} !== 2'b00 || d !== x) begin errors++; $display("FAIL b2b_rd write=%b data=%h want 0 %h", w, d, x); end
  endtask

  task automatic test_reset_flight;
    int a, r, seen; logic w, e; logic [511:0] d;
    resp_ready = 0;
    for (int k = 0; k < 3; k++) send(0, 32'hC0, '0, '0, a);
    rst = 1;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errors++; $display("FAIL rf_ready_in_rst got=%b want=0", req_ready); end
    @(posedge clk);
    #1;
    checks++;
    if ({resp_valid, resp_write, resp_err, resp_data} !== '0) begin
      errors++; $display("FAIL rf_flush valid=%b write=%b err=%b data=%h want all 0", resp_valid, resp_write, resp_err, resp_data);
    end
    rst = 0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errors++; $display("FAIL rf_ready_release got=%b want=1", req_ready); end
    resp_ready = 1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (resp_valid) seen++;
      @(posedge clk);
      #1;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rf_stale got=%0d responses want=0", seen); end
    send(0, 32'h140, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (d !== pat_m || r !== a + 2) begin errors++; $display("FAIL rf_fresh lat=%0d data=%h want 2 %h", r - a, d, pat_m); end
  endtask

`ifdef LINE_MEM_PARITY_EN
  task automatic test_parity;
    int a, r; logic w, e; logic [511:0] d;
    send(0, 32'hC0, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (last_perr !== '0) begin errors++; $display("FAIL par_clean got=%h want=0", last_perr); end
    send(1, 32'h240, '1, pat_p, a);
    get_resp(w, e, d, r);
    inj_perr = 1;
    send(1, 32'h240, 32'h3, pat_p, a);
    inj_perr = 0;
    get_resp(w, e, d, r);
    send(0, 32'h240, '0, '0, a);
    get_resp(w, e, d, r);
    checks++;
    if (last_perr !== 32'h3 || d !== pat_p) begin
      errors++; $display("FAIL par_inject perr=%h data=%h want 00000003 %h", last_perr, d, pat_p);
    end
  endtask
`endif

  initial begin
    pat_aa = {64{8'hAA}};
    pat_m = {{31{16'hFFFF}}, 16'h1234};
    pat_p = {32{16'hA5C3}};
    pat_q = {16{32'h13579BDF}};
    test_reset();
    test_write_read();
    test_mask();
    test_oor();
    test_backpressure();
    test_back_to_back();
    test_reset_flight();
`ifdef LINE_MEM_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
